// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD state timer: digit type, digit limits
// and the display FSM state codes.
package timer_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;
  localparam bcd_digit_t SEC1_MAX  = 4'd5;

  typedef enum logic [2:0] {
    ST_CLOCK     = 3'd0,
    ST_TIMER     = 3'd1,
    ST_STOPWATCH = 3'd2,
    ST_ALARM     = 3'd3,
    ST_SET       = 3'd4
  } disp_state_e;

  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d, input bcd_digit_t max);
    return (d > max) ? max : d;
  endfunction

  function automatic logic secs_le(input bcd_digit_t s1, input bcd_digit_t s0,
                                   input int unsigned lim);
    return (32'(s1) * 32'd10 + 32'(s0)) <= lim;
  endfunction

endpackage

// File: rtl/state_timer_bcd_if.sv
// Control/status bundle between the display FSM and state_timer_bcd.
// The warn status line exists only when TIMER_WARN_EN is defined.
interface state_timer_bcd_if #(
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned STATE_W    = 3
);
  localparam int unsigned N = MIN_DIGITS + 2;

  logic               tick;
  logic               pauseToggle;
  logic               load;
  logic               countUp;
  logic [4*N-1:0]     initialValue;
  logic [STATE_W-1:0] currentState;
  logic [4*N-1:0]     digitsOut;
  logic               running;
  logic               finished;
`ifdef TIMER_WARN_EN
  logic               warn;

  modport master (
    output tick, pauseToggle, load, countUp, initialValue, currentState,
    input  digitsOut, running, finished, warn
  );
  modport slave (
    input  tick, pauseToggle, load, countUp, initialValue, currentState,
    output digitsOut, running, finished, warn
  );
`else
  modport master (
    output tick, pauseToggle, load, countUp, initialValue, currentState,
    input  digitsOut, running, finished
  );
  modport slave (
    input  tick, pauseToggle, load, countUp, initialValue, currentState,
    output digitsOut, running, finished
  );
`endif

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit with saturating load and wrap at MAX; co flags a wrap
// (carry when counting up, borrow when counting down) on an enabled cycle.
module bcd_digit_counter
  import timer_pkg::*;
#(
  parameter bcd_digit_t MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t loadVal,
  output bcd_digit_t value,
  output logic       co,
  output logic       isMax,
  output logic       isZero
);

  assign isMax  = (value == MAX);
  assign isZero = (value == '0);
  assign co     = en && (up ? isMax : isZero);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= bcd_sat(loadVal, MAX);
    end else if (en) begin
      if (up) value <= isMax  ? '0  : value + 4'd1;
      else    value <= isZero ? MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/state_timer_bcd.sv
// mm..m:ss BCD countdown/count-up timer, active only in FSM state STATE_ID.
// Optional warn output (last ten seconds of a countdown) via TIMER_WARN_EN.
module state_timer_bcd
  import timer_pkg::*;
#(
  parameter int unsigned STATE_ID   = 0,
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned STATE_W    = 3
) (
  input logic              slowclk,
  input logic              reset,
  state_timer_bcd_if.slave bus
);

  localparam int unsigned N = MIN_DIGITS + 2;

  logic       active, loadq, qualified, step;
  logic       upper_max, upper_zero, terminal, next_term;
  logic       paused, paused_d, prevPause;
  logic       finished_q, finished_d, running_q;
  logic [N-1:0] en, co, is_max, is_zero;
  bcd_digit_t val [N];

  assign active    = (bus.currentState == STATE_W'(STATE_ID));
  assign loadq     = active && bus.load;
  assign qualified = active && bus.tick && !paused && !finished_q;

  assign upper_max  = &is_max[N-1:1];
  assign upper_zero = &is_zero[N-1:1];
  assign terminal   = bus.countUp ? (is_max[0] && upper_max) : (is_zero[0] && upper_zero);
  // One step short of terminal, so finished rises on the same edge as the value.
  assign next_term  = bus.countUp ? ((val[0] == DIGIT_MAX - 4'd1) && upper_max)
                                  : ((val[0] == 4'd1) && upper_zero);

  assign step = qualified && !terminal && !loadq;
  assign en   = {co[N-2:0], step};

  for (genvar i = 0; i < N; i++) begin : g_dig
    localparam bcd_digit_t DMAX = (i == 1) ? SEC1_MAX : DIGIT_MAX;

    bcd_digit_counter #(.MAX(DMAX)) u_dig (
      .clk     (slowclk),
      .reset   (reset),
      .en      (en[i]),
      .up      (bus.countUp),
      .load    (loadq),
      .loadVal (bus.initialValue[BCD_W*i +: BCD_W]),
      .value   (val[i]),
      .co      (co[i]),
      .isMax   (is_max[i]),
      .isZero  (is_zero[i])
    );

    assign bus.digitsOut[BCD_W*i +: BCD_W] = val[i];
  end

  always_comb begin
    paused_d = paused;
    if (active && bus.pauseToggle && !prevPause) paused_d = !paused;

    finished_d = finished_q;
    if (loadq)
      finished_d = 1'b0;
    else if ((qualified && (terminal || next_term)) || co[N-1])
      finished_d = 1'b1;
  end

`ifdef TIMER_WARN_EN
  logic warn_q, warn_d, near_end, mins_zero;

  assign mins_zero = &is_zero[N-1:2];

  // Evaluated on the post-edge value so warn lines up with digitsOut.
  always_comb begin
    if (loadq)
      near_end = (bus.initialValue[BCD_W*N-1:2*BCD_W] == '0) &&
                 secs_le(bcd_sat(bus.initialValue[7:4], SEC1_MAX),
                         bcd_sat(bus.initialValue[3:0], DIGIT_MAX), 10);
    else if (step)
      near_end = mins_zero && secs_le(val[1], val[0], 11);
    else
      near_end = mins_zero && secs_le(val[1], val[0], 10);
    warn_d = !bus.countUp && !finished_d && near_end;
  end

  assign bus.warn = warn_q;
`endif

  always_ff @(posedge slowclk) begin
    if (reset) begin
      paused     <= 1'b0;
      prevPause  <= 1'b0;
      finished_q <= 1'b0;
      running_q  <= 1'b0;
`ifdef TIMER_WARN_EN
      warn_q     <= 1'b0;
`endif
    end else begin
      paused     <= paused_d;
      prevPause  <= bus.pauseToggle;
      finished_q <= finished_d;
      running_q  <= active && !paused_d && !finished_d;
`ifdef TIMER_WARN_EN
      warn_q     <= warn_d;
`endif
    end
  end

  assign bus.running  = running_q;
  assign bus.finished = finished_q;

endmodule
